// File: rtl/divider_pkg.sv
// divider_pkg: shared types and constants for the restoring divider.
//   state_t            - control FSM states
//   DEFAULT_WIDTH      - default operand/result width in bits
//   DEFAULT_ITERATIONS - quotient bits produced per division at the default width
package divider_pkg;

   localparam int unsigned DEFAULT_WIDTH      = 8;
   localparam int unsigned DEFAULT_ITERATIONS = DEFAULT_WIDTH;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SHIFT,
      ST_TRY,
      ST_DONE
   } state_t;

endpackage

// File: rtl/divider_if.sv
// divider_if: operand/result bundle of the divider.
//   Run        - start a division (level, sampled in IDLE)
//   ClrA_LoadB - in IDLE: clear A/X and load dividend from S into B
//   S          - dividend (with ClrA_LoadB) or divisor (with Run)
//   Aval/Xval  - remainder register and its extension bit
//   Bval       - dividend register, becomes the quotient
//   Done       - result valid
//   DivZero    - divisor register holds zero
interface divider_if
   import divider_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
);

   logic             Run;
   logic             ClrA_LoadB;
   logic [WIDTH-1:0] S;
   logic [WIDTH-1:0] Aval;
   logic [WIDTH-1:0] Bval;
   logic             Xval;
   logic             Done;
   logic             DivZero;

   modport master (
      output Run, ClrA_LoadB, S,
      input  Aval, Bval, Xval, Done, DivZero
   );

   modport slave (
      input  Run, ClrA_LoadB, S,
      output Aval, Bval, Xval, Done, DivZero
   );

endinterface

// File: rtl/divider_reg_unit.sv
// divider_reg_unit: X/A/B/D registers with the load, shift and trial-subtract
// datapath of a restoring divider. One control strobe is active per cycle.
//   Clk, Reset  - clock, synchronous active-high reset
//   clr_load    - clear {X,A}, load B from s_in
//   load_d      - load D from s_in, clear {X,A}, capture the divisor-zero flag
//   shift_en    - shift {X,A,B} left one bit
//   try_en      - trial subtract D from {X,A}; keep the result if non-negative
//   s_in        - operand input
//   a_q,b_q,x_q - register contents
//   div_zero_q  - divisor captured at the last load was zero
module divider_reg_unit
   import divider_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             clr_load,
   input  logic             load_d,
   input  logic             shift_en,
   input  logic             try_en,
   input  logic [WIDTH-1:0] s_in,
   output logic [WIDTH-1:0] a_q,
   output logic [WIDTH-1:0] b_q,
   output logic             x_q,
   output logic             div_zero_q
);

   logic [WIDTH-1:0] d_q;
   logic [WIDTH:0]   diff;

   // MSB of the (WIDTH+1)-bit difference is the borrow: set means {X,A} < D.
   assign diff = {x_q, a_q} - {1'b0, d_q};

   always_ff @(posedge Clk) begin
      if (Reset) begin
         x_q        <= 1'b0;
         a_q        <= '0;
         b_q        <= '0;
         d_q        <= '0;
         div_zero_q <= 1'b0;
      end else if (clr_load) begin
         {x_q, a_q} <= '0;
         b_q        <= s_in;
      end else if (load_d) begin
         {x_q, a_q} <= '0;
         d_q        <= s_in;
         div_zero_q <= (s_in == '0);
      end else if (shift_en) begin
         {x_q, a_q, b_q} <= {a_q, b_q, 1'b0};
      end else if (try_en) begin
         if (!diff[WIDTH]) begin
            {x_q, a_q} <= diff;
         end
         b_q[0] <= ~diff[WIDTH];
      end
   end

endmodule

// File: rtl/divider_unit.sv
// divider_unit: unsigned restoring divider, one quotient bit per SHIFT/TRY pair.
//   Clk   - clock, rising edge
//   Reset - synchronous active-high reset
//   bus   - divider_if slave: Run/ClrA_LoadB/S in, Aval/Bval/Xval/Done/DivZero out
module divider_unit
   import divider_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic      Clk,
   input  logic      Reset,
   divider_if.slave  bus
);

   localparam int unsigned    CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q;
   logic          clr_load, load_d, shift_en, try_en, done;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         if (load_d) begin
            cnt_q <= '0;
         end else if (try_en) begin
            cnt_q <= cnt_q + CW'(1);
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      clr_load = 1'b0;
      load_d   = 1'b0;
      shift_en = 1'b0;
      try_en   = 1'b0;
      done     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // Loading the dividend takes priority over starting a division.
            if (bus.ClrA_LoadB) begin
               clr_load = 1'b1;
            end else if (bus.Run) begin
               state_d = ST_LOAD;
            end
         end
         ST_LOAD: begin
            load_d  = 1'b1;
            state_d = ST_SHIFT;
         end
         ST_SHIFT: begin
            shift_en = 1'b1;
            state_d  = ST_TRY;
         end
         ST_TRY: begin
            try_en  = 1'b1;
            state_d = (cnt_q == LAST) ? ST_DONE : ST_SHIFT;
         end
         ST_DONE: begin
            done = 1'b1;
            if (!bus.Run) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   divider_reg_unit #(
      .WIDTH (WIDTH)
   ) u_regs (
      .Clk        (Clk),
      .Reset      (Reset),
      .clr_load   (clr_load),
      .load_d     (load_d),
      .shift_en   (shift_en),
      .try_en     (try_en),
      .s_in       (bus.S),
      .a_q        (bus.Aval),
      .b_q        (bus.Bval),
      .x_q        (bus.Xval),
      .div_zero_q (bus.DivZero)
   );

   assign bus.Done = done;

endmodule

// File: doc/divider_unit.md
DIVIDER_UNIT -- requirements
Module: divider_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits.
REQ-002 SHALL have port Clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port Reset  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port Run  input  1  level; starts a division when sampled high in IDLE.
REQ-005 SHALL have port ClrA_LoadB  input  1  in IDLE: clears A and X, loads B from S.
REQ-006 SHALL have port S  input  WIDTH  dividend (ClrA_LoadB) or divisor (Run).
REQ-007 SHALL have port Aval  output  WIDTH  A register: partial remainder, final remainder.
REQ-008 SHALL have port Bval  output  WIDTH  B register: dividend, shifting to quotient.
REQ-009 SHALL have port Xval  output  1  extension bit above A (A is WIDTH+1 bits with X).
REQ-010 SHALL have port Done  output  1  high only in DONE state.
REQ-011 SHALL have port DivZero  output  1  divisor register is zero; valid from LOAD onward.

Function
REQ-012 SHALL implement unsigned restoring division of B by D, one quotient bit per two cycles.
REQ-013 SHALL use FSM states IDLE, LOAD, SHIFT, TRY, DONE.
REQ-014 IDLE: ClrA_LoadB high -> {X,A}=0, B=S; else Run high -> LOAD; ClrA_LoadB wins if both high.
REQ-015 LOAD (1 cycle): D=S, {X,A}=0, bit counter=0, DivZero=(S==0); -> SHIFT.
REQ-016 SHIFT (1 cycle): {X,A,B} shifted left 1, B[0]=0; -> TRY.
REQ-017 TRY (1 cycle): diff={X,A}-{0,D} in WIDTH+1 bits; if diff MSB==0 then {X,A}=diff, B[0]=1, else unchanged, B[0]=0.
REQ-018 TRY: counter increments; counter==WIDTH-1 -> DONE, else -> SHIFT.
REQ-019 Latency: Done SHALL rise 2*WIDTH+2 rising edges after the edge sampling Run in IDLE (18 for WIDTH=8).
REQ-020 DONE: Bval=quotient, Aval=remainder, Xval=0, all registers hold; stay while Run high; Run low -> IDLE.
REQ-021 Divisor zero SHALL not be special-cased in datapath: quotient all ones, remainder = dividend, DivZero=1.
REQ-022 ClrA_LoadB and S SHALL be ignored outside IDLE; Run ignored in LOAD/SHIFT/TRY.
REQ-023 Results SHALL remain on Aval/Bval in IDLE after DONE until next ClrA_LoadB or LOAD.
REQ-024 New division from IDLE without ClrA_LoadB SHALL divide the previous quotient in B.

Reset
REQ-025 Reset high at any edge, in any state incl. mid-division: state=IDLE, A=0, X=0, B=0, D=0, counter=0.
REQ-026 After reset Done=0, DivZero=0, Aval=0, Bval=0, Xval=0; Reset overrides Run and ClrA_LoadB.

Structure
REQ-027 Package divider_pkg SHALL hold the state enum, WIDTH default and iteration-count constant.
REQ-028 Sub-module divider_reg_unit SHALL hold X, A, B, D and shift/load/subtract datapath; divider_unit holds FSM and counter.
REQ-029 Subtractor SHALL be WIDTH+1 bits; no multiplier or divide operator.

Verification
REQ-030 ClrA_LoadB with S=200, Run with S=7 -> after 18 cycles Done=1, Bval=28, Aval=4, Xval=0, DivZero=0.
REQ-031 Dividend 255, divisor 1 -> Bval=255, Aval=0; dividend 5, divisor 10 -> Bval=0, Aval=5.
REQ-032 Dividend 100, divisor 0 -> Bval=255, Aval=100, DivZero=1 from cycle after LOAD.
REQ-033 Reset asserted in 5th TRY -> next edge IDLE, all outputs 0; Run held high -> fresh 18-cycle division of B=0.
REQ-034 Run held high through DONE -> Done stays 1, no restart; Run low one cycle -> IDLE, Done=0.
REQ-035 ClrA_LoadB and Run high together in IDLE -> B loaded, no LOAD; ClrA_LoadB pulsed mid-division -> no effect.
